mdu_sched: RTL and testbench

Multi-cycle scheduler for the E-stage multiply/divide unit. It accepts decoded MDU operations from E, latches operands, and computes the result once at accept. It holds the result for a fixed latency before committing it to HI/LO, and generates the D-stage stall for any MDU-dependent instruction while an operation is pending. It also services MTHI/MTLO writes and supports cancellation of an in-flight operation on exception flush.

---
 rtl/mdu_pkg.sv | 38 +++
 rtl/mdu_arith.sv | 66 ++++++
 rtl/mdu_sched.sv | 120 ++++++++++++
 tb/tb_mdu_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Purpose: shared MDU op encoding, scheduler states and divide corner-case constants.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  // Divide by zero: quotient saturates to all-ones, remainder is the dividend.
  localparam logic [31:0] DIV0_QUOT    = 32'hFFFF_FFFF;
  // Signed overflow: most-negative / -1 yields most-negative with zero remainder.
  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOT     = 32'h8000_0000;
  localparam logic [31:0] OVF_REM      = 32'h0000_0000;

  // Ops that occupy the unit for several cycles and commit through the result register.
  function automatic logic is_start_op(mdu_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(mdu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Purpose: combinational multiply/divide producing the full 64-bit {hi,lo} result.
// Latency: zero cycles (pure combinational).
// Backpressure: none; result is valid whenever op/rs/rt are stable.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] result
);

  mdu_op_t     op_t;
  logic        signed_div;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_b_safe;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq;
  logic [31:0] sr;

  assign op_t = mdu_op_t'(op);

  // Sign-extended operands give the signed product modulo 2^64.
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'b0, rs} * {32'b0, rt};

  // Signed divide runs on magnitudes, then restores signs: quotient truncates
  // toward zero, remainder follows the dividend.
  assign signed_div = (op_t == OP_DIV);
  assign div_a      = (signed_div && rs[31]) ? -rs : rs;
  assign div_b      = (signed_div && rt[31]) ? -rt : rt;
  assign div_b_safe = (div_b == 32'd0) ? 32'd1 : div_b;
  assign uq         = div_a / div_b_safe;
  assign ur         = div_a % div_b_safe;
  assign sq         = (signed_div && (rs[31] ^ rt[31])) ? -uq : uq;
  assign sr         = (signed_div && rs[31]) ? -ur : ur;

  // Select the result for the requested op, applying the divide corner cases.
  always_comb begin
    result = '0;
    case (op_t)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV: begin
        if (rt == 32'd0)
          result = {rs, DIV0_QUOT};
        else if ((rs == OVF_DIVIDEND) && (rt == OVF_DIVISOR))
          result = {OVF_REM, OVF_QUOT};
        else
          result = {sr, sq};
      end
      OP_DIVU: begin
        if (rt == 32'd0)
          result = {rs, DIV0_QUOT};
        else
          result = {ur, uq};
      end
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_sched.sv
// Purpose: E-stage MDU scheduler: accepts ops, holds the result for a fixed latency, commits HI/LO.
// Latency: MULT/MULTU commit MULT_CYCLES edges after accept, DIV/DIVU DIV_CYCLES; MTHI/MTLO one edge.
// Backpressure: stall_d holds a dependent D instruction during the accept cycle and every busy cycle.
module mdu_sched
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid_e,
  input  logic [2:0]  op_e,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  input  logic        md_use_d,
  input  logic        cancel,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        start,
  output logic        busy,
  output logic        stall_d
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mdu_op_t          op;
  mdu_state_t       state_q;
  mdu_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      result_q;
  logic [63:0]      arith_result;
  logic             mthi_we;
  logic             mtlo_we;
  logic             commit;

  assign op = mdu_op_t'(op_e);

  mdu_arith u_arith (
    .op     (op_e),
    .rs     (rs_e),
    .rt     (rt_e),
    .result (arith_result)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Next state: leave RUN on the final count or on cancel, whichever comes first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cancel || (cnt_q == '0)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: accept and MTHI/MTLO strobes only in IDLE; commit only on an uncancelled final count.
  always_comb begin
    start   = 1'b0;
    mthi_we = 1'b0;
    mtlo_we = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid_e && !cancel) begin
          start   = is_start_op(op);
          mthi_we = (op == OP_MTHI);
          mtlo_we = (op == OP_MTLO);
        end
      end
      ST_RUN:  commit = !cancel && (cnt_q == '0);
      default: ;
    endcase
  end

  assign busy    = (state_q == ST_RUN);
  assign stall_d = md_use_d & (start | busy);

  // Latch the result and latency at accept, then count down while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      result_q <= '0;
    end else if (start) begin
      cnt_q    <= is_div_op(op) ? DIV_LOAD : MULT_LOAD;
      result_q <= arith_result;
    end else if (busy) begin
      if (cancel)
        cnt_q <= '0;
      else if (cnt_q != '0)
        cnt_q <= cnt_q - CNT_ONE;
    end
  end

  // Architectural HI/LO: committed result or direct MTHI/MTLO write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= result_q[63:32];
      lo <= result_q[31:0];
    end else begin
      if (mthi_we) hi <= rs_e;
      if (mtlo_we) lo <= rs_e;
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Purpose: self-checking bench for mdu_sched: fixed vectors, corner sequences, random ops vs model.
// Latency: checks commit exactly MULT_CYCLES/DIV_CYCLES edges after accept.
// Backpressure: checks stall_d length for dependent D instructions.
module tb_mdu_sched;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        op_valid_e = 1'b0;
  logic [2:0]  op_e = 3'd0;
  logic [31:0] rs_e = '0;
  logic [31:0] rt_e = '0;
  logic        md_use_d = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        start;
  logic        busy;
  logic        stall_d;

  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ehi;
    logic [31:0] elo;
    bit          use_d;
  } vec_t;

  vec_t vecs[10];

  mdu_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op_valid_e (op_valid_e),
    .op_e       (op_e),
    .rs_e       (rs_e),
    .rt_e       (rt_e),
    .md_use_d   (md_use_d),
    .cancel     (cancel),
    .hi         (hi),
    .lo         (lo),
    .start      (start),
    .busy       (busy),
    .stall_d    (stall_d)
  );

  always #5 clk = ~clk;

  function automatic bit is_start(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic int lat(input logic [2:0] op);
    return ((op == OP_DIV) || (op == OP_DIVU)) ? DC : MC;
  endfunction

  // Reference: 64-bit integer arithmetic; 64-bit signed divide makes the overflow case fall out naturally.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ref_result = '0;
    case (op)
      OP_MULT:  begin sq = sa * sb; ref_result = sq; end
      OP_MULTU: begin uq = ua * ub; ref_result = uq; end
      OP_DIV: begin
        if (b == 32'd0) ref_result = {a, 32'hFFFF_FFFF};
        else begin sq = sa / sb; sr = sa - sq * sb; ref_result = {sr[31:0], sq[31:0]}; end
      end
      OP_DIVU: begin
        if (b == 32'd0) ref_result = {a, 32'hFFFF_FFFF};
        else begin uq = ua / ub; ur = ua - uq * ub; ref_result = {ur[31:0], uq[31:0]}; end
      end
      default: ref_result = {m_hi, m_lo};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The stall keeps start-class ops away from a running unit; the bench must never present one.
  always @(negedge clk) begin
    if (reset_n)
      assert (!(busy && op_valid_e && is_start(op_e)))
        else $error("start-class op presented while busy");
  end

  // Issue one multi-cycle op (called away from clock edges, with the unit idle) and check
  // accept, hold, latency, stall length and committed value.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input bit use_d);
    int n;
    int stalls;
    bit early;
    logic [63:0] old;
    old = {m_hi, m_lo};
    op_valid_e = 1'b1; op_e = op; rs_e = a; rt_e = b; md_use_d = use_d;
    #1;
    chk({name, ".start"}, start, 1);
    stalls = stall_d ? 1 : 0;
    @(posedge clk); #1;
    op_valid_e = 1'b0; op_e = OP_NONE; rs_e = $urandom; rt_e = $urandom;
    n = 0;
    early = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (stall_d) stalls++;
      if ({hi, lo} !== old) early = 1'b1;
    end
    chk({name, ".latency"}, n, lat(op));
    chk({name, ".hold"}, early, 0);
    chk({name, ".result"}, {hi, lo}, exp);
    chk({name, ".stalls"}, stalls, use_d ? lat(op) + 1 : 0);
    md_use_d = 1'b0;
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  // MTHI/MTLO write (optionally cancelled): no stall, visible the cycle after the edge.
  task automatic mt_op(input string name, input logic [2:0] op, input logic [31:0] a, input bit c);
    op_valid_e = 1'b1; op_e = op; rs_e = a; cancel = c; md_use_d = 1'b1;
    #1;
    chk({name, ".stall"}, stall_d, 0);
    chk({name, ".start"}, start, 0);
    @(posedge clk); #1;
    op_valid_e = 1'b0; op_e = OP_NONE; cancel = 1'b0; md_use_d = 1'b0;
    if (!c) begin
      if (op == OP_MTHI) m_hi = a;
      else m_lo = a;
    end
    @(negedge clk);
    chk({name, ".hilo"}, {hi, lo}, {m_hi, m_lo});
    chk({name, ".busy"}, busy, 0);
  endtask

  // Cancel an op during its k-th busy cycle (1-based); hi/lo must never change.
  task automatic cancel_op(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int k);
    op_valid_e = 1'b1; op_e = op; rs_e = a; rt_e = b;
    @(posedge clk); #1;
    op_valid_e = 1'b0; op_e = OP_NONE;
    for (int i = 1; i < k; i++) begin
      @(posedge clk); #1;
    end
    cancel = 1'b1;
    @(negedge clk);
    chk({name, ".busy_at_cancel"}, busy, 1);
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    chk({name, ".busy_after"}, busy, 0);
    chk({name, ".hilo_after"}, {hi, lo}, {m_hi, m_lo});
    for (int i = 0; i < lat(op) + 2; i++) @(negedge clk);
    chk({name, ".no_late_commit"}, {hi, lo}, {m_hi, m_lo});
    chk({name, ".still_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[1] = '{OP_DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0};
    vecs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,        1'b1};
    vecs[5] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b1};
    vecs[6] = '{OP_DIV,   32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0};
    vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        1'b0};
    vecs[8] = '{OP_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,        1'b0};
    vecs[9] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,        32'h0,        1'b1};

    // Reset state, with a dependent D instruction present.
    #1 reset_n = 1'b0;
    md_use_d = 1'b1;
    #1;
    chk("reset.hi", hi, 0);
    chk("reset.lo", lo, 0);
    chk("reset.busy", busy, 0);
    chk("reset.start", start, 0);
    chk("reset.stall", stall_d, 0);
    #10 reset_n = 1'b1;
    md_use_d = 1'b0;
    @(negedge clk);

    // Fixed vectors, issued back-to-back at the earliest accept point.
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
             {vecs[i].ehi, vecs[i].elo}, vecs[i].use_d);

    // MTHI/MTLO, including a cancelled write.
    mt_op("mthi", OP_MTHI, 32'h1234_5678, 1'b0);
    mt_op("mtlo", OP_MTLO, 32'hCAFE_F00D, 1'b0);
    mt_op("mthi_cancel", OP_MTHI, 32'hDEAD_BEEF, 1'b1);

    // Cancel in IDLE suppresses the accept.
    op_valid_e = 1'b1; op_e = OP_MULT; rs_e = 32'd9; rt_e = 32'd9; cancel = 1'b1;
    #1;
    chk("idle_cancel.start", start, 0);
    @(posedge clk); #1;
    op_valid_e = 1'b0; op_e = OP_NONE; cancel = 1'b0;
    @(negedge clk);
    chk("idle_cancel.busy", busy, 0);
    chk("idle_cancel.hilo", {hi, lo}, {m_hi, m_lo});

    // Cancel mid-flight and on the final count.
    cancel_op("div_cancel3", OP_DIV, 32'd100, 32'd7, 3);
    cancel_op("div_cancel_last", OP_DIVU, 32'd100, 32'd7, DC);
    cancel_op("mult_cancel_last", OP_MULT, 32'd6, 32'd7, MC);

    // Asynchronous reset in the middle of a MULT.
    op_valid_e = 1'b1; op_e = OP_MULT; rs_e = 32'd1000; rt_e = 32'd1000;
    @(posedge clk); #1;
    op_valid_e = 1'b0; op_e = OP_NONE;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset.hilo", {hi, lo}, 64'd0);
    chk("midreset.busy", busy, 0);
    m_hi = '0; m_lo = '0;
    #3 reset_n = 1'b1;
    @(negedge clk);
    run_op("post_reset_mult", OP_MULT, 32'd3, 32'd4, 64'd12, 1'b0);

    // Random ops against the reference model.
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(1, 6));
      ra  = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9)) ^ {32{rb[31]}};
      if (is_start(rop))
        run_op($sformatf("rnd%0d", i), rop, ra, rb, ref_result(rop, ra, rb), 1'($urandom_range(0, 1)));
      else
        mt_op($sformatf("rnd%0d", i), rop, ra, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
